// File: rtl/float_discriminant_sequencer.sv
// Discriminant D = b*b - 4*a*c computed by time-multiplexing one multiplier and one subtractor.
// Each operation is issued, awaited under a watchdog, and aborted early on unit error.
module float_discriminant_sequencer #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err,
  output logic            busy,
  // Shared multiplier
  output logic            mult_up_valid_o,
  output logic [FLEN-1:0] mult_op_a_o,
  output logic [FLEN-1:0] mult_op_b_o,
  input  logic            mult_busy_i,
  input  logic            mult_down_valid_i,
  input  logic [FLEN-1:0] mult_res_i,
  input  logic            mult_error_i,
  // Subtractor
  output logic            sub_up_valid_o,
  output logic [FLEN-1:0] sub_op_a_o,
  output logic [FLEN-1:0] sub_op_b_o,
  input  logic            sub_busy_i,
  input  logic            sub_down_valid_i,
  input  logic [FLEN-1:0] sub_res_i,
  input  logic            sub_error_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
  localparam logic [63:0] FourDbl = 64'h4010_0000_0000_0000;
  localparam logic [FLEN-1:0] Four = FLEN'(FourDbl);

  typedef enum logic [3:0] {
    StIdle,
    StIssBb,
    StWtBb,
    StIssAc,
    StWtAc,
    StIssFour,
    StWtFour,
    StIssSub,
    StWtSub,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [FLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [FLEN-1:0] bb_q, bb_d, ac_q, ac_d, ac4_q, ac4_d, d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_sticky_q, err_sticky_d;
  logic            res_vld_q, res_vld_d;
  logic [FLEN-1:0] res_q, res_d;
  logic            res_neg_q, res_neg_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  logic            unit_dv, unit_err, timeout;
  logic [FLEN-1:0] unit_res;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    bb_d         = bb_q;
    ac_d         = ac_q;
    ac4_d        = ac4_q;
    d_d          = d_q;
    cnt_d        = '0;
    err_sticky_d = err_sticky_q;
    res_vld_d    = 1'b0;
    res_d        = res_q;
    res_neg_d    = res_neg_q;
    err_d        = err_q;

    mult_up_valid_o = 1'b0;
    sub_up_valid_o  = 1'b0;
    mult_op_a_o     = b_q;
    mult_op_b_o     = b_q;
    sub_op_a_o      = bb_q;
    sub_op_b_o      = ac4_q;

    unique case (state_q)
      StIssAc: begin
        mult_op_a_o = a_q;
        mult_op_b_o = c_q;
      end
      StIssFour: begin
        mult_op_a_o = Four;
        mult_op_b_o = ac_q;
      end
      default: ;
    endcase

    // Only one unit is ever active, so a single result path serves all wait states.
    unit_dv  = (state_q == StWtSub) ? sub_down_valid_i : mult_down_valid_i;
    unit_err = (state_q == StWtSub) ? sub_error_i : mult_error_i;
    unit_res = (state_q == StWtSub) ? sub_res_i : mult_res_i;
    timeout  = (cnt_q == TimeoutCnt);

    case (state_q)
      StIdle: begin
        if (arg_vld) begin
          a_d          = a;
          b_d          = b;
          c_d          = c;
          err_sticky_d = 1'b0;
          state_d      = StIssBb;
        end
      end
      StIssBb: begin
        if (!mult_busy_i) begin
          mult_up_valid_o = 1'b1;
          state_d         = StWtBb;
        end
      end
      StIssAc: begin
        if (!mult_busy_i) begin
          mult_up_valid_o = 1'b1;
          state_d         = StWtAc;
        end
      end
      StIssFour: begin
        if (!mult_busy_i) begin
          mult_up_valid_o = 1'b1;
          state_d         = StWtFour;
        end
      end
      StIssSub: begin
        if (!sub_busy_i) begin
          sub_up_valid_o = 1'b1;
          state_d        = StWtSub;
        end
      end
      StWtBb, StWtAc, StWtFour, StWtSub: begin
        if (unit_dv && !unit_err) begin
          unique case (state_q)
            StWtBb: begin
              bb_d    = unit_res;
              state_d = StIssAc;
            end
            StWtAc: begin
              ac_d    = unit_res;
              state_d = StIssFour;
            end
            StWtFour: begin
              ac4_d   = unit_res;
              state_d = StIssSub;
            end
            default: begin
              d_d     = unit_res;
              state_d = StDone;
            end
          endcase
        end else if (unit_dv || timeout) begin
          err_sticky_d = 1'b1;
          state_d      = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);

    // Result registers load on entry to DONE and hold until the next one.
    if (state_d == StDone) begin
      res_vld_d = 1'b1;
      err_d     = err_sticky_d;
      res_d     = err_sticky_d ? '0 : d_d;
      res_neg_d = !err_sticky_d && d_d[FLEN-1] && (|d_d[FLEN-2:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      bb_q         <= '0;
      ac_q         <= '0;
      ac4_q        <= '0;
      d_q          <= '0;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
      res_vld_q    <= 1'b0;
      res_q        <= '0;
      res_neg_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      bb_q         <= bb_d;
      ac_q         <= ac_d;
      ac4_q        <= ac4_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      err_sticky_q <= err_sticky_d;
      res_vld_q    <= res_vld_d;
      res_q        <= res_d;
      res_neg_q    <= res_neg_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign res_vld      = res_vld_q;
  assign res          = res_q;
  assign res_negative = res_neg_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_float_discriminant_sequencer.sv
// Bench for float_discriminant_sequencer: behavioural FP units with programmable latency and a
// reference model built from real arithmetic on stage results and stage durations.
module tb_float_discriminant_sequencer;

  localparam int unsigned FLEN    = 64;
  localparam int unsigned TIMEOUT = 8;

  localparam logic [63:0] One  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] Two  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] Four = 64'h4010_0000_0000_0000;
  localparam logic [63:0] Nan  = 64'h7FF8_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arg_vld;
  logic [63:0] a, b, c;
  logic res_vld, res_negative, err, busy;
  logic [63:0] res;

  logic m_up, m_busy, m_dv, m_err;
  logic [63:0] m_a, m_b, m_res;
  logic s_up, s_busy, s_dv, s_err;
  logic [63:0] s_a, s_b, s_res;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  float_discriminant_sequencer #(
    .FLEN    (FLEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .arg_vld           (arg_vld),
    .a                 (a),
    .b                 (b),
    .c                 (c),
    .res_vld           (res_vld),
    .res               (res),
    .res_negative      (res_negative),
    .err               (err),
    .busy              (busy),
    .mult_up_valid_o   (m_up),
    .mult_op_a_o       (m_a),
    .mult_op_b_o       (m_b),
    .mult_busy_i       (m_busy),
    .mult_down_valid_i (m_dv),
    .mult_res_i        (m_res),
    .mult_error_i      (m_err),
    .sub_up_valid_o    (s_up),
    .sub_op_a_o        (s_a),
    .sub_op_b_o        (s_b),
    .sub_busy_i        (s_busy),
    .sub_down_valid_i  (s_dv),
    .sub_res_i         (s_res),
    .sub_error_i       (s_err)
  );

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
    return $realtobits($bitstoreal(x) * $bitstoreal(y));
  endfunction

  function automatic logic [63:0] fsub(input logic [63:0] x, input logic [63:0] y);
    return $realtobits($bitstoreal(x) - $bitstoreal(y));
  endfunction

  // Behavioural units: result appears lat cycles after the issue cycle; stall never answers.
  int m_lat = 2, s_lat = 3;
  bit m_stall = 1'b0;
  logic m_pend, s_pend;
  int m_rem, s_rem;
  logic [63:0] m_res_q, s_res_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend <= 1'b0; m_rem <= 0; m_res_q <= '0;
    end else if (m_up && !m_pend) begin
      m_pend <= 1'b1; m_rem <= m_lat - 1; m_res_q <= fmul(m_a, m_b);
    end else if (m_pend && m_rem == 0 && !m_stall) begin
      m_pend <= 1'b0;
    end else if (m_pend && m_rem > 0) begin
      m_rem <= m_rem - 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_pend <= 1'b0; s_rem <= 0; s_res_q <= '0;
    end else if (s_up && !s_pend) begin
      s_pend <= 1'b1; s_rem <= s_lat - 1; s_res_q <= fsub(s_a, s_b);
    end else if (s_pend && s_rem == 0) begin
      s_pend <= 1'b0;
    end else if (s_pend && s_rem > 0) begin
      s_rem <= s_rem - 1;
    end
  end

  assign m_busy = m_pend;
  assign m_dv   = m_pend && (m_rem == 0) && !m_stall;
  assign m_res  = m_res_q;
  assign m_err  = m_dv && is_nan(m_res_q);
  assign s_busy = s_pend;
  assign s_dv   = s_pend && (s_rem == 0);
  assign s_res  = s_res_q;
  assign s_err  = s_dv && is_nan(s_res_q);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          acc;
    int          done_cyc;
    logic [63:0] res;
    bit          neg;
    bit          err;
    int          m_iss;
    int          s_iss;
    bit          has_lit;
    logic [63:0] lit_res;
    int          lit_lat;
  } exp_t;

  exp_t expq[$];
  logic [63:0] hold_res = '0;
  bit hold_neg = 1'b0, hold_err = 1'b0;
  int m_cnt = 0, s_cnt = 0;
  int last_done = 0, last_acc = 0;

  // Stage k in {b*b, a*c, 4*ac, bb-4ac}: issue cycle + latency cycles; abort on NaN or stall.
  task automatic model(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] xc,
                       input int acc, output exp_t e);
    logic [63:0] st[4];
    int lat;
    st[0] = fmul(xb, xb);
    st[1] = fmul(xa, xc);
    st[2] = fmul(Four, st[1]);
    st[3] = fsub(st[0], st[2]);
    lat = 1;
    e.err = 1'b0; e.m_iss = 0; e.s_iss = 0; e.has_lit = 1'b0; e.lit_res = '0; e.lit_lat = 0;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) e.m_iss++; else e.s_iss++;
      if (k < 3 && m_stall) begin
        lat += 2 + TIMEOUT;
        e.err = 1'b1;
        break;
      end
      lat += 1 + ((k < 3) ? m_lat : s_lat);
      if (is_nan(st[k])) begin
        e.err = 1'b1;
        break;
      end
    end
    e.acc      = acc;
    e.done_cyc = acc + lat;
    e.res      = e.err ? 64'd0 : st[3];
    e.neg      = !e.err && st[3][63] && (st[3][62:0] != 63'd0);
  endtask

  task automatic issue(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] xc,
                       input bit has_lit, input logic [63:0] lit_res, input int lit_lat);
    exp_t e;
    a = xa; b = xb; c = xc; arg_vld = 1'b1;
    model(xa, xb, xc, cyc, e);
    e.has_lit = has_lit; e.lit_res = lit_res; e.lit_lat = lit_lat;
    expq.push_back(e);
    last_done = e.done_cyc;
    last_acc  = e.acc;
    @(negedge clk);
    arg_vld = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc <= last_done) @(negedge clk);
  endtask

  task automatic reset_now();
    #2 rst = 1'b0;
    #1;
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_res", res, 64'd0);
    chk("rst_neg", 64'(res_negative), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    expq.delete();
    hold_res = '0; hold_neg = 1'b0; hold_err = 1'b0;
    m_cnt = 0; s_cnt = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  // Per-cycle compare against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_res_vld", 64'(res_vld), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_res", res, 64'd0);
    end else begin
      bit exp_vld, exp_busy;
      if (m_up) begin
        m_cnt++;
        chk("mult_issue_while_busy", 64'(m_pend), 64'd0);
      end
      if (s_up) begin
        s_cnt++;
        chk("sub_issue_while_busy", 64'(s_pend), 64'd0);
      end
      exp_vld  = (expq.size() > 0) && (cyc == expq[0].done_cyc);
      exp_busy = (expq.size() > 0) && (cyc > expq[0].acc) && (cyc <= expq[0].done_cyc);
      chk("res_vld", 64'(res_vld), 64'(exp_vld));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_vld) begin
        hold_res = expq[0].res;
        hold_neg = expq[0].neg;
        hold_err = expq[0].err;
        chk("mult_issues", 64'(m_cnt), 64'(expq[0].m_iss));
        chk("sub_issues", 64'(s_cnt), 64'(expq[0].s_iss));
        if (expq[0].has_lit) begin
          chk("lit_res", res, expq[0].lit_res);
          chk("lit_latency", 64'(cyc - expq[0].acc), 64'(expq[0].lit_lat));
        end
        m_cnt = 0; s_cnt = 0;
        void'(expq.pop_front());
      end
      chk("res", res, hold_res);
      chk("res_negative", 64'(res_negative), 64'(hold_neg));
      chk("err", 64'(err), 64'(hold_err));
    end
  end

  function automatic logic [63:0] rand_op();
    int sel, v;
    sel = int'($urandom_range(0, 19));
    v   = int'($urandom_range(0, 16)) - 8;
    if (sel < 12) return $realtobits($itor(v));
    else if (sel < 16) return $realtobits($itor(v) / 4.0);
    else if (sel < 19) return {$urandom, $urandom};
    else return Nan;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    arg_vld = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    m_lat = 2; s_lat = 3;
    issue(One, Four, Two, 1'b1, 64'h4020_0000_0000_0000, 5 + 3 * 2 + 3);
    wait_done();
    issue(One, Two, One, 1'b1, 64'h0, 14);
    wait_done();
    issue(Two, One, One, 1'b1, 64'hC01C_0000_0000_0000, 14);
    wait_done();
    // NaN in a: aborts at a*c, subtractor never issued.
    issue(Nan, One, One, 1'b1, 64'h0, 1 + 2 * (1 + 2));
    wait_done();

    // Extra arg_vld pulses while busy are ignored.
    issue(One, 64'h4008_0000_0000_0000, Two, 1'b0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      a = rand_op(); b = rand_op(); c = rand_op(); arg_vld = 1'b1;
      @(negedge clk);
      arg_vld = 1'b0;
      @(negedge clk);
    end
    wait_done();

    // Reset during the 4*ac wait.
    m_lat = 3; s_lat = 2;
    issue(Two, Four, One, 1'b0, '0, 0);
    while (cyc < last_acc + 11) @(negedge clk);
    reset_now();
    repeat (3) @(negedge clk);
    issue(One, Four, Two, 1'b1, 64'h4020_0000_0000_0000, 5 + 3 * 3 + 2);
    wait_done();

    for (int n = 0; n < 40; n++) begin
      m_lat = int'($urandom_range(1, 5));
      s_lat = int'($urandom_range(1, 5));
      issue(rand_op(), rand_op(), rand_op(), 1'b0, '0, 0);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Multiplier never answers: watchdog abort 1+TIMEOUT+1 cycles after the issue cycle.
    m_stall = 1'b1;
    issue(One, Four, Two, 1'b1, 64'h0, 1 + 1 + TIMEOUT + 1);
    wait_done();
    @(negedge clk);
    reset_now();
    m_stall = 1'b0;
    m_lat = 1; s_lat = 1;
    issue(Two, One, One, 1'b1, 64'hC01C_0000_0000_0000, 5 + 3 + 1);
    wait_done();
    repeat (2) @(negedge clk);

    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
